// File: rtl/scpad_body_req_queue.sv
// Body-side request buffer for one scratchpad frontend port: in-order request FIFO,
// credit-limited SRAM read issue and an in-order response FIFO back to the frontend.
module scpad_body_req_queue #(
  parameter int          IDX       = 0,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fe_req_valid,
  input  logic              fe_req_write,
  input  logic [ADDR_W-1:0] fe_req_addr,
  input  logic [DATA_W-1:0] fe_req_wdata,
  output logic              fe_stall,
  output logic              sram_req_valid,
  input  logic              sram_req_ready,
  output logic              sram_req_write,
  output logic [ADDR_W-1:0] sram_req_addr,
  output logic [DATA_W-1:0] sram_req_wdata,
  input  logic              sram_rvalid,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned RPTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned RCNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SUM_W  = RCNT_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);
  localparam logic [SUM_W-1:0] CREDITS   = SUM_W'(RSP_DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RSP_DEPTH < 1 ||
      (RSP_DEPTH & (RSP_DEPTH - 1)) != 0 || IDX < 0) begin : g_param_check
    $error("scpad_body_req_queue: illegal parameter set");
  end

  logic              req_wr_q    [DEPTH];
  logic [ADDR_W-1:0] req_addr_q  [DEPTH];
  logic [DATA_W-1:0] req_wdata_q [DEPTH];
  logic [PTR_W-1:0]  req_wptr, req_rptr;
  logic [CNT_W-1:0]  req_count;

  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RPTR_W-1:0] rsp_wptr, rsp_rptr;
  logic [RCNT_W-1:0] rsp_count;
  logic [RCNT_W-1:0] outstanding;
  logic              err_q;

  logic req_push, req_drop, req_fire, rd_fire, has_credit;
  logic rsp_push, rsp_pop, stray_rvalid;

  function automatic logic [PTR_W-1:0] req_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [RPTR_W-1:0] rsp_inc(input logic [RPTR_W-1:0] p);
    return (p == RPTR_W'(RSP_DEPTH - 1)) ? '0 : p + RPTR_W'(1);
  endfunction

  // Credits come from registered state only; a slot freed this cycle is usable next cycle.
  assign has_credit     = (SUM_W'(outstanding) + SUM_W'(rsp_count)) < CREDITS;
  assign req_push       = fe_req_valid && (req_count != FULL_CNT);
  assign req_drop       = fe_req_valid && (req_count == FULL_CNT);
  assign sram_req_write = req_wr_q[req_rptr];
  assign sram_req_addr  = req_addr_q[req_rptr];
  assign sram_req_wdata = req_wdata_q[req_rptr];
  assign sram_req_valid = (req_count != '0) && (sram_req_write || has_credit);
  assign req_fire       = sram_req_valid && sram_req_ready;
  assign rd_fire        = req_fire && !sram_req_write;
  assign rsp_push       = sram_rvalid && (outstanding != '0);
  assign stray_rvalid   = sram_rvalid && (outstanding == '0);
  assign res_valid      = (rsp_count != '0);
  assign res_rdata      = rsp_mem[rsp_rptr];
  assign rsp_pop        = res_valid && res_ready;

  // Stall one entry early: the frontend latch may already hold a request.
  assign fe_stall = (req_count >= STALL_CNT);
  assign busy     = (req_count != '0) || (outstanding != '0) || (rsp_count != '0);
  assign err      = err_q;

  // Request FIFO.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_wptr  <= '0;
      req_rptr  <= '0;
      req_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        req_wr_q[PTR_W'(i)]    <= 1'b0;
        req_addr_q[PTR_W'(i)]  <= '0;
        req_wdata_q[PTR_W'(i)] <= '0;
      end
    end else begin
      if (req_push) begin
        req_wr_q[req_wptr]    <= fe_req_write;
        req_addr_q[req_wptr]  <= fe_req_addr;
        req_wdata_q[req_wptr] <= fe_req_wdata;
        req_wptr              <= req_inc(req_wptr);
      end
      if (req_fire) begin
        req_rptr <= req_inc(req_rptr);
      end
      if (req_push && !req_fire) begin
        req_count <= req_count + CNT_W'(1);
      end else if (!req_push && req_fire) begin
        req_count <= req_count - CNT_W'(1);
      end
    end
  end

  // Outstanding-read tracking, response FIFO and sticky error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outstanding <= '0;
      rsp_wptr    <= '0;
      rsp_rptr    <= '0;
      rsp_count   <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        rsp_mem[RPTR_W'(i)] <= '0;
      end
    end else begin
      if (rd_fire && !rsp_push) begin
        outstanding <= outstanding + RCNT_W'(1);
      end else if (!rd_fire && rsp_push) begin
        outstanding <= outstanding - RCNT_W'(1);
      end
      if (rsp_push) begin
        rsp_mem[rsp_wptr] <= sram_rdata;
        rsp_wptr          <= rsp_inc(rsp_wptr);
      end
      if (rsp_pop) begin
        rsp_rptr <= rsp_inc(rsp_rptr);
      end
      if (rsp_push && !rsp_pop) begin
        rsp_count <= rsp_count + RCNT_W'(1);
      end else if (!rsp_push && rsp_pop) begin
        rsp_count <= rsp_count - RCNT_W'(1);
      end
      if (req_drop || stray_rvalid) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/scpad_body_req_queue.md
Name: scpad_body_req_queue

Overview:
- Body-side request buffer for one scratchpad frontend port. It sits directly downstream of the frontend request latch.
- Accepts latched vector-core requests and generates the frontend stall.
- Issues requests in order to the SRAM bank with a valid/ready handshake.
- Tracks outstanding reads with credits and returns read data in order through a response FIFO toward the frontend response latch.

Parameters:
- IDX, 0, frontend port index; informational only, no functional effect.
- ADDR_W, 12, scratchpad address width.
- DATA_W, 32, read/write data width.
- DEPTH, 4, request FIFO entries (>=2, power of 2).
- RSP_DEPTH, 4, response credits; max reads in flight plus responses buffered (power of 2).

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- fe_req_valid  in  1  latched request valid.
- fe_req_write  in  1  1 = write, 0 = read.
- fe_req_addr  in  ADDR_W  request address.
- fe_req_wdata  in  DATA_W  write data.
- fe_stall  out  1  stall to frontend; frontend holds its latch while high.
- sram_req_valid  out  1  SRAM request valid.
- sram_req_ready  in  1  SRAM accepts request.
- sram_req_write  out  1  SRAM write enable.
- sram_req_addr  out  ADDR_W  SRAM address.
- sram_req_wdata  out  DATA_W  SRAM write data.
- sram_rvalid  in  1  SRAM read data valid; in-order, any latency.
- sram_rdata  in  DATA_W  SRAM read data.
- res_valid  out  1  response valid to frontend.
- res_ready  in  1  frontend consumes response.
- res_rdata  out  DATA_W  response read data.
- busy  out  1  any entry queued, in flight, or buffered.
- err  out  1  sticky protocol error.

Behaviour:
- Single clock domain, clock clk.
- n_rst asynchronous, active low. On reset: all FIFO pointers, counts, the outstanding counter and err clear. All outputs reset to 0, except fe_stall = 0 because count = 0.
- Request FIFO:
  - count range 0..DEPTH.
  - Push when fe_req_valid && count < DEPTH.
  - fe_req_valid with count == DEPTH drops the request and sets err.
- fe_stall = (count >= DEPTH-1), derived from registered state only.
  - The threshold reserves one slot for the request already registered in the frontend latch.
- Issue path:
  - sram_req_* present the FIFO head combinationally.
  - sram_req_valid = count > 0 && (head.write || credits > 0).
  - credits = RSP_DEPTH - outstanding - rsp_count.
  - Fire = sram_req_valid && sram_req_ready. Fire pops the head; a read fire also increments outstanding.
  - Head-of-line blocking is intended: a read head with 0 credits blocks later writes.
  - Write fires produce no response.
- Return path:
  - sram_rvalid decrements outstanding and pushes sram_rdata into the response FIFO.
  - sram_rvalid while outstanding == 0 sets err; the data is dropped.
  - Credits guarantee the response FIFO never overflows.
- Response:
  - res_valid = rsp_count > 0; res_rdata = response FIFO head.
  - Pop on res_valid && res_ready. res_rdata is stable while res_valid && !res_ready.
- Simultaneous events in one cycle:
  - Request push and pop: count unchanged; pointers both advance.
  - Read fire and sram_rvalid: outstanding unchanged.
  - Response push and pop: rsp_count unchanged.
  - Credits are computed from registered values; a credit freed this cycle is usable next cycle.
- Latency: a request pushed at cycle N is presented on sram_req_valid at N+1 at the earliest (FIFO registered). Response at the earliest 1 cycle after sram_rvalid.
- Pointers wrap modulo DEPTH / RSP_DEPTH.
- busy = count != 0 || outstanding != 0 || rsp_count != 0.
- err is cleared only by reset.

Test Plan:
- Reset mid-operation: 3 queued requests, 2 reads outstanding; assert n_rst low asynchronously → count = 0, busy = 0, fe_stall = 0, res_valid = 0 immediately. A subsequent stray sram_rvalid sets err = 1.
- Single read: push read addr 0x010, sram_req_ready = 1, sram_rvalid with 0xDEADBEEF 2 cycles later → sram_req_valid 1 cycle after push; res_valid 1 cycle after rvalid with res_rdata = 0xDEADBEEF; busy falls after the res_ready pop.
- Stall threshold: sram_req_ready = 0, push 3 writes → fe_stall rises after the 3rd push (count = 3). A 4th push is accepted (count = 4). A 5th push is dropped and err = 1.
- Credit limit: res_ready = 0, 6 reads pushed, SRAM ready and returning each read 1 cycle later → exactly 4 reads issue; sram_req_valid stays 0 while rsp_count = 4. Raising res_ready issues the remaining 2 in order; data returns in push order.
- Write passthrough: write addr 0x0FF, wdata 0x12345678 → one sram fire with write = 1 and matching addr/data, no res_valid, outstanding unchanged.
- Wrap and simultaneity: 20 alternating reads/writes streamed at full rate with random sram_req_ready/res_ready → no err, all 10 reads returned in order, final count = outstanding = rsp_count = 0.
